// File: rtl/cpc_rom_pkg.sv
// Shared types and constants for the CPC eight-ROM expansion board controller.
package cpc_rom_pkg;

  // EEPROM write-cycle sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Status register bit positions
  localparam int unsigned STAT_PROG_EN = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  // Upper-ROM select port is any I/O write with A13 low; index within A15..A8
  localparam int unsigned A13_BIT = 5;

  // Strobe positions inside the synchronizer pipeline
  localparam int unsigned SB_IORQ = 0;
  localparam int unsigned SB_MREQ = 1;
  localparam int unsigned SB_RD   = 2;
  localparam int unsigned SB_WR   = 3;
  localparam int unsigned SB_W    = 4;

endpackage

// File: rtl/cpc_bus_sync.sv
// Two-stage pipeline for Z80 strobes, A15..A8 and data, plus strobe edge pulses.
module cpc_bus_sync
  import cpc_rom_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_b,
  input  logic       mreq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic [7:0] a_hi,
  input  logic [7:0] d,
  output logic       iorq_s,
  output logic       mreq_s,
  output logic       iorq_d,
  output logic       wr_fall,
  output logic       wr_rise,
  output logic       rd_rise,
  output logic [7:0] a_hi_s,
  output logic [7:0] d_s
);

  logic [SB_W-1:0] strb_in;
  logic [SB_W-1:0] strb_1;
  logic [SB_W-1:0] strb_2;
  logic [7:0]      a_hi_1;
  logic [7:0]      d_1;
  logic            rd_d;
  logic            wr_d;

  assign strb_in = {wr_b, rd_b, mreq_b, iorq_b};

  // Shared pipeline keeps strobes, address and data cycle-aligned; *_d holds last stage-2 value
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_1 <= '1;
      strb_2 <= '1;
      a_hi_1 <= '0;
      a_hi_s <= '0;
      d_1    <= '0;
      d_s    <= '0;
      iorq_d <= 1'b1;
      rd_d   <= 1'b1;
      wr_d   <= 1'b1;
    end else begin
      strb_1 <= strb_in;
      strb_2 <= strb_1;
      a_hi_1 <= a_hi;
      a_hi_s <= a_hi_1;
      d_1    <= d;
      d_s    <= d_1;
      iorq_d <= strb_2[SB_IORQ];
      rd_d   <= strb_2[SB_RD];
      wr_d   <= strb_2[SB_WR];
    end
  end

  assign iorq_s  = strb_2[SB_IORQ];
  assign mreq_s  = strb_2[SB_MREQ];
  assign wr_fall = wr_d & ~strb_2[SB_WR];
  assign wr_rise = ~wr_d & strb_2[SB_WR];
  assign rd_rise = ~rd_d & strb_2[SB_RD];

endmodule

// File: rtl/cpc_rom_bank_ctrl.sv
// Upper-ROM bank controller: ROM select tracking, chip-select decode, EEPROM write gating and timing.
module cpc_rom_bank_ctrl
  import cpc_rom_pkg::*;
#(
  parameter logic [4:0]  ROM_BASE   = 5'd0,
  parameter logic [7:0]  CTRL_PORT  = 8'hFB,
  parameter int unsigned TWC_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_hi,
  input  logic [7:0] d,
  input  logic       iorq_b,
  input  logic       mreq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       romen_b,
  input  logic [7:0] en_mask,
  output logic [3:0] romcs_b,
  output logic       roma14,
  output logic [3:0] rom_we_b,
  output logic       romdis,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       busy
);

  localparam int unsigned CNT_W = ($clog2(TWC_CYCLES) > 16) ? $clog2(TWC_CYCLES) : 16;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       slot_q;
  logic             claim_q;
  logic             prog_en;
  logic             overrun;
  logic [CNT_W-1:0] cnt;

  logic       iorq_s, mreq_s, iorq_d;
  logic       wr_fall, wr_rise, rd_rise;
  logic [7:0] a_hi_s, d_s;

  logic io_wr_start, sel_wr, ctrl_wr, mem_wr_start, stat_rd_end, wg_s, ovr_set;
  logic hit, wg;

  cpc_bus_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .iorq_b  (iorq_b),
    .mreq_b  (mreq_b),
    .rd_b    (rd_b),
    .wr_b    (wr_b),
    .a_hi    (a_hi),
    .d       (d),
    .iorq_s  (iorq_s),
    .mreq_s  (mreq_s),
    .iorq_d  (iorq_d),
    .wr_fall (wr_fall),
    .wr_rise (wr_rise),
    .rd_rise (rd_rise),
    .a_hi_s  (a_hi_s),
    .d_s     (d_s)
  );

  // Bus cycle decode on the synchronized view; iorq_d qualifies the read trailing edge
  assign io_wr_start  = wr_fall & ~iorq_s;
  assign sel_wr       = io_wr_start & ~a_hi_s[A13_BIT];
  assign ctrl_wr      = io_wr_start & (a_hi_s == CTRL_PORT);
  assign mem_wr_start = wr_fall & ~mreq_s & a_hi_s[7] & a_hi_s[6];
  assign stat_rd_end  = rd_rise & ~iorq_d & (a_hi_s == CTRL_PORT);
  assign wg_s         = prog_en & claim_q & mem_wr_start;
  assign ovr_set      = (state == ST_BUSY) & wg_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (wg_s)         state_nxt = ST_WRITE;
      ST_WRITE: if (wr_rise)      state_nxt = ST_BUSY;
      ST_BUSY:  if (cnt == '0)    state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: chip selects, write enables and status respond to the live bus
  always_comb begin
    busy     = (state == ST_BUSY);
    hit      = claim_q & ~romen_b & a_hi[7] & a_hi[6];
    wg       = prog_en & claim_q & ((state == ST_IDLE) | (state == ST_WRITE))
               & ~mreq_b & a_hi[7] & a_hi[6];
    romcs_b  = 4'hF;
    rom_we_b = 4'hF;
    if (hit)        romcs_b[slot_q[2:1]]  = 1'b0;
    if (wg & ~wr_b) rom_we_b[slot_q[2:1]] = 1'b0;
    roma14   = slot_q[0];
    romdis   = claim_q;
    dout_oe  = ~iorq_b & ~rd_b & (a_hi == CTRL_PORT);
    dout     = 8'h00;
    dout[STAT_PROG_EN] = prog_en;
    dout[STAT_BUSY]    = busy;
    dout[STAT_OVERRUN] = overrun;
  end

  // Select/control registers, write-cycle timer and sticky overrun flag (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q  <= 3'd0;
      claim_q <= 1'b0;
      prog_en <= 1'b0;
      overrun <= 1'b0;
      cnt     <= '0;
    end else begin
      if (sel_wr) begin
        slot_q  <= d_s[2:0];
        claim_q <= (d_s[7:3] == ROM_BASE) & en_mask[d_s[2:0]];
      end
      if (ctrl_wr) prog_en <= d_s[0];
      if ((state == ST_WRITE) && wr_rise)     cnt <= CNT_W'(TWC_CYCLES - 1);
      else if ((state == ST_BUSY) && (cnt != '0)) cnt <= cnt - CNT_W'(1);
      if (ovr_set)          overrun <= 1'b1;
      else if (stat_rd_end) overrun <= 1'b0;
    end
  end

endmodule
